// File: rtl/pixel_word_packer.sv
// Capture-side pixel packer: turns one RGB+threshold pixel per cycle into channel word pairs
// (colour split, binary replicate or binary bit-packed) and buffers them in a show-ahead FIFO.
module pixel_word_packer #(
   parameter int PIX_W      = 12,
   parameter int WORD_W     = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int FRAME_W    = 800,
   parameter int FRAME_H    = 600
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [1:0]                    i_mode,
   input  logic                          i_sof,
   input  logic                          i_valid,
   input  logic [PIX_W-1:0]              i_r,
   input  logic [PIX_W-1:0]              i_g,
   input  logic [PIX_W-1:0]              i_b,
   input  logic                          i_thr,
   output logic [WORD_W-1:0]             o_data0,
   output logic [WORD_W-1:0]             o_data1,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_level,
   output logic                          o_busy,
   output logic                          o_frame_done,
   output logic                          o_overflow,
   output logic [1:0]                    o_state
);

   localparam int NPIX  = FRAME_W * FRAME_H;
   localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int PK_W  = $clog2(WORD_W);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
   logic [PK_W-1:0]     pack_cnt_q, pack_cnt_d;
   logic [WORD_W-1:0]   pack_word_q, pack_word_d;
   logic                frame_done_q, frame_done_d;
   logic                ovf_q, ovf_d;
   logic [WORD_W-1:0]   mem0_q [FIFO_DEPTH];
   logic [WORD_W-1:0]   mem0_d [FIFO_DEPTH];
   logic [WORD_W-1:0]   mem1_q [FIFO_DEPTH];
   logic [WORD_W-1:0]   mem1_d [FIFO_DEPTH];
   logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]         count_q, count_d;

   logic                accept, last, push, pop, push_ok;
   logic [1:0]          mode_eff;
   logic [CNT_W-1:0]    idx;
   logic [PK_W-1:0]     pk;
   logic [WORD_W-1:0]   word_cur, word_new, push_d0, push_d1;
   logic                unused_bits;

   // Only the top 10 bits of each component reach the colour words.
   assign unused_bits = ^{i_r[PIX_W-11:0], i_g[PIX_W-11:0], i_b[PIX_W-11:0]};

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      pix_cnt_d    = pix_cnt_q;
      pack_cnt_d   = pack_cnt_q;
      pack_word_d  = pack_word_q;
      frame_done_d = 1'b0;
      ovf_d        = ovf_q;
      wr_d         = wr_q;
      rd_d         = rd_q;
      count_d      = count_q;
      mem0_d       = mem0_q;
      mem1_d       = mem1_q;
      push         = 1'b0;
      push_d0      = '0;
      push_d1      = '0;

      // A pixel coincident with i_sof belongs to the new frame and its mode.
      accept   = i_valid & ((state_q == S_ACTIVE) | i_sof);
      mode_eff = i_sof ? i_mode : mode_q;
      if (mode_eff == 2'd3) mode_eff = 2'd0;
      idx      = i_sof ? '0 : pix_cnt_q;
      pk       = i_sof ? '0 : pack_cnt_q;
      word_cur = i_sof ? '0 : pack_word_q;
      word_new = word_cur | (WORD_W'(i_thr) << pk);
      last     = accept && (idx == CNT_W'(NPIX - 1));

      if (i_sof) begin
         mode_d      = i_mode;
         pix_cnt_d   = '0;
         pack_cnt_d  = '0;
         pack_word_d = '0;
         ovf_d       = 1'b0;
         state_d     = S_ACTIVE;
      end

      if (accept) begin
         pix_cnt_d = last ? '0 : idx + CNT_W'(1);
         case (mode_eff)
            2'd1: begin
               push    = 1'b1;
               push_d0 = i_thr ? WORD_W'(16'h7FFF) : '0;
               push_d1 = push_d0;
            end
            2'd2: begin
               if ((pk == PK_W'(WORD_W - 1)) || last) begin
                  push        = 1'b1;
                  push_d0     = word_new;
                  pack_cnt_d  = '0;
                  pack_word_d = '0;
               end else begin
                  pack_cnt_d  = pk + PK_W'(1);
                  pack_word_d = word_new;
               end
            end
            default: begin
               push    = 1'b1;
               push_d0 = WORD_W'({1'b0, i_g[PIX_W-1 -: 5], i_b[PIX_W-1 -: 10]});
               push_d1 = WORD_W'({1'b0, i_g[PIX_W-6 -: 5], i_r[PIX_W-1 -: 10]});
            end
         endcase
      end

      if (last) begin
         state_d      = S_DONE;
         frame_done_d = 1'b1;
      end

      // A full FIFO still takes a push when the head leaves in the same cycle.
      pop     = (count_q != '0) & i_ready;
      push_ok = push & ((count_q < (AW+1)'(FIFO_DEPTH)) | pop);
      if (push & ~push_ok) ovf_d = 1'b1;
      if (push_ok) begin
         mem0_d[wr_q] = push_d0;
         mem1_d[wr_q] = push_d1;
      end
      wr_d    = wr_q + AW'(push_ok);
      rd_d    = rd_q + AW'(pop);
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         mode_q       <= '0;
         pix_cnt_q    <= '0;
         pack_cnt_q   <= '0;
         pack_word_q  <= '0;
         frame_done_q <= 1'b0;
         ovf_q        <= 1'b0;
         wr_q         <= '0;
         rd_q         <= '0;
         count_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem0_q[i] <= '0;
            mem1_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         pix_cnt_q    <= pix_cnt_d;
         pack_cnt_q   <= pack_cnt_d;
         pack_word_q  <= pack_word_d;
         frame_done_q <= frame_done_d;
         ovf_q        <= ovf_d;
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         count_q      <= count_d;
         mem0_q       <= mem0_d;
         mem1_q       <= mem1_d;
      end
   end

   assign o_data0      = mem0_q[rd_q];
   assign o_data1      = mem1_q[rd_q];
   assign o_valid      = (count_q != '0);
   assign o_level      = count_q;
   assign o_busy       = (state_q == S_ACTIVE);
   assign o_frame_done = frame_done_q;
   assign o_overflow   = ovf_q;
   assign o_state      = state_q;

endmodule

// File: tb/tb_pixel_word_packer.sv
// Directed bench for pixel_word_packer on a 4x2 frame with a 4-entry FIFO.
// Handshake: a word pair moves when o_valid & i_ready are both high at a rising edge.
module tb_pixel_word_packer;

   localparam int PIX_W = 12;
   localparam int WORD_W = 16;
   localparam int DEPTH = 4;
   localparam int FW = 4;
   localparam int FH = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [1:0]        mode = '0;
   logic              sof = 1'b0;
   logic              valid = 1'b0;
   logic [PIX_W-1:0]  r = '0, g = '0, b = '0;
   logic              thr = 1'b0;
   logic              ready = 1'b0;
   logic [WORD_W-1:0] data0, data1;
   logic              o_valid, busy, frame_done, overflow;
   logic [2:0]        level;
   logic [1:0]        state;

   int checks = 0;
   int failures = 0;
   logic [WORD_W-1:0] exp_q[$];

   pixel_word_packer #(
      .PIX_W(PIX_W), .WORD_W(WORD_W), .FIFO_DEPTH(DEPTH), .FRAME_W(FW), .FRAME_H(FH)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_sof(sof), .i_valid(valid),
      .i_r(r), .i_g(g), .i_b(b), .i_thr(thr),
      .o_data0(data0), .o_data1(data1), .o_valid(o_valid), .i_ready(ready),
      .o_level(level), .o_busy(busy), .o_frame_done(frame_done),
      .o_overflow(overflow), .o_state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic              sof;
      logic [1:0]        mode;
      logic              valid;
      logic              thr;
      logic [PIX_W-1:0]  r, g, b;
      logic              ready;
      logic              e_valid;
      logic [WORD_W-1:0] e_d0, e_d1;
      logic [2:0]        e_level;
      logic              e_done;
      logic              e_busy;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(int s, int m, int v, int t, int rr, int gg, int bb, int rdy,
                               int ev, int d0, int d1, int lv, int dn, int bs);
      vec_t x;
      x.sof = 1'(s);  x.mode = 2'(m);  x.valid = 1'(v);  x.thr = 1'(t);
      x.r = PIX_W'(rr);  x.g = PIX_W'(gg);  x.b = PIX_W'(bb);  x.ready = 1'(rdy);
      x.e_valid = 1'(ev);  x.e_d0 = WORD_W'(d0);  x.e_d1 = WORD_W'(d1);
      x.e_level = 3'(lv);  x.e_done = 1'(dn);  x.e_busy = 1'(bs);
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int s, input int m, input int v, input int t, input int rdy);
      sof = 1'(s);  mode = 2'(m);  valid = 1'(v);  thr = 1'(t);  ready = 1'(rdy);
   endtask

   initial begin
      // clock/reset
      #3;
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_data0", 32'(data0), 0);
      chk("rst_data1", 32'(data1), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(frame_done), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_state", 32'(state), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // mode 0 pixel, then a full mode 1 frame with a free-running consumer
      vecs[0]  = mk(1, 0, 1, 0, 'hABC, 'h5A5, 'h3FF, 1, 1, 'h2CFF, 'h26AF, 1, 0, 1);
      vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
      vecs[2]  = mk(1, 1, 1, 1, 0, 0, 0, 1, 1, 'h7FFF, 'h7FFF, 1, 0, 1);
      vecs[3]  = mk(0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1);
      vecs[4]  = mk(0, 1, 1, 1, 0, 0, 0, 1, 1, 'h7FFF, 'h7FFF, 1, 0, 1);
      vecs[5]  = mk(0, 1, 1, 1, 0, 0, 0, 1, 1, 'h7FFF, 'h7FFF, 1, 0, 1);
      vecs[6]  = mk(0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1);
      vecs[7]  = mk(0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1);
      vecs[8]  = mk(0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1);
      vecs[9]  = mk(0, 1, 1, 1, 0, 0, 0, 1, 1, 'h7FFF, 'h7FFF, 1, 1, 0);
      vecs[10] = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      vecs[11] = mk(0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 12; i++) begin
         drive(int'(vecs[i].sof), int'(vecs[i].mode), int'(vecs[i].valid),
               int'(vecs[i].thr), int'(vecs[i].ready));
         r = vecs[i].r;  g = vecs[i].g;  b = vecs[i].b;
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vecs[i].e_valid));
         if (vecs[i].e_valid) begin
            chk($sformatf("vec%0d_data0", i), 32'(data0), 32'(vecs[i].e_d0));
            chk($sformatf("vec%0d_data1", i), 32'(data1), 32'(vecs[i].e_d1));
         end
         chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_level));
         chk($sformatf("vec%0d_done", i), 32'(frame_done), 32'(vecs[i].e_done));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      end
      chk("mode1_state_done", 32'(state), 2);

      // mode 2 frame packed into one padded word, then a stray pixel
      begin
         logic [7:0] pat;
         pat = 8'h8D;
         for (int i = 0; i < 8; i++) begin
            drive(int'(i == 0), 2, 1, int'(pat[i]), 0);
            tick();
            if (i == 6) chk("pack_no_early_push", 32'(level), 0);
         end
      end
      chk("pack_valid", 32'(o_valid), 1);
      chk("pack_data0", 32'(data0), 'h008D);
      chk("pack_data1", 32'(data1), 0);
      chk("pack_level", 32'(level), 1);
      chk("pack_done", 32'(frame_done), 1);
      drive(0, 2, 1, 1, 0);
      tick();
      chk("stray_level", 32'(level), 1);
      chk("stray_done", 32'(frame_done), 0);
      drive(0, 2, 0, 0, 1);
      tick();
      chk("pack_drained", 32'(o_valid), 0);

      // mode 2 restart after 5 pixels: partial word discarded
      for (int i = 0; i < 5; i++) begin
         drive(int'(i == 0), 2, 1, 1, 1);
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         drive(int'(i == 0), 2, 1, int'(i != 0), 1);
         tick();
         if (i == 0) chk("restart_no_push", 32'(level), 0);
         if (i == 4) chk("restart_counter", 32'(o_valid), 0);
      end
      chk("restart_valid", 32'(o_valid), 1);
      chk("restart_data0", 32'(data0), 'h00FE);
      chk("restart_done", 32'(frame_done), 1);
      drive(0, 2, 0, 0, 1);
      tick();

      // overflow with a stalled consumer
      begin
         logic [5:0] pat;
         pat = 6'b110101;
         for (int i = 0; i < 6; i++) begin
            drive(int'(i == 0), 1, 1, int'(pat[i]), 0);
            if (i < DEPTH) exp_q.push_back(pat[i] ? 16'h7FFF : 16'h0000);
            tick();
            if (i == 3) begin
               chk("ovf_not_yet", 32'(overflow), 0);
               chk("ovf_level_full", 32'(level), 4);
            end
         end
      end
      chk("ovf_level", 32'(level), 4);
      chk("ovf_flag", 32'(overflow), 1);
      drive(0, 1, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) begin
         logic [WORD_W-1:0] e;
         e = exp_q.pop_front();
         chk($sformatf("drain%0d_valid", i), 32'(o_valid), 1);
         chk($sformatf("drain%0d_data0", i), 32'(data0), 32'(e));
         chk($sformatf("drain%0d_data1", i), 32'(data1), 32'(e));
         tick();
      end
      chk("drain_empty", 32'(o_valid), 0);
      chk("drain_ovf_sticky", 32'(overflow), 1);
      drive(1, 1, 0, 0, 1);
      tick();
      chk("ovf_cleared", 32'(overflow), 0);

      // full FIFO with simultaneous push and pop
      begin
         logic [3:0] pat;
         pat = 4'b1101;
         for (int i = 0; i < 4; i++) begin
            drive(int'(i == 0), 1, 1, int'(pat[i]), 0);
            tick();
         end
      end
      chk("full_level", 32'(level), 4);
      drive(0, 1, 1, 0, 1);
      tick();
      chk("pushpop_level", 32'(level), 4);
      chk("pushpop_ovf", 32'(overflow), 0);
      chk("pushpop_head", 32'(data0), 0);

      // asynchronous reset mid-stream
      drive(0, 1, 1, 1, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(o_valid), 0);
      chk("arst_level", 32'(level), 0);
      chk("arst_data0", 32'(data0), 0);
      chk("arst_data1", 32'(data1), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_ovf", 32'(overflow), 0);
      chk("arst_state", 32'(state), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pixel_word_packer.md
# pixel_word_packer

Parametrised capture-side packer between the RAW-to-RGB/threshold stage and the two SDRAM write FIFOs of the camera pipeline. It takes one pixel per cycle (RGB plus a 1-bit threshold flag) and produces two WORD_W-bit channel words in one of three runtime modes: colour split, binary replicate, or binary bit-packed (WORD_W pixels per word). Words are buffered in an internal show-ahead FIFO and drained with a valid/ready handshake. The block tracks frame boundaries and flags overflow.

## Interface
- PIX_W, 12: width of each input colour component; must be ≥ 12.
- WORD_W, 16: output word width per channel; must be ≥ 16. Bits above 15 are zero in modes 0 and 1.
- FIFO_DEPTH, 16: number of entries, each holding a word pair; must be a power of two, ≥ 2.
- FRAME_W, 800 / FRAME_H, 600: pixels per line / lines per frame; NPIX = FRAME_W*FRAME_H.

Ports:
- i_clk  in  1  sole clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_mode  in  2  0 = colour, 1 = binary replicate, 2 = binary packed, 3 = treated as 0. Sampled only on i_sof.
- i_sof  in  1  start-of-frame pulse.
- i_valid  in  1  pixel strobe.
- i_r, i_g, i_b  in  PIX_W each  colour components.
- i_thr  in  1  threshold flag.
- o_data0, o_data1  out  WORD_W each  FIFO head, channel 0 / channel 1.
- o_valid  out  1  FIFO not empty.
- i_ready  in  1  consumer accepts the head word pair.
- o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- o_busy  out  1  state == ACTIVE.
- o_frame_done  out  1  one-cycle pulse.
- o_overflow  out  1  sticky drop flag.

## Operation
- FSM:
  - IDLE → ACTIVE on i_sof.
  - ACTIVE → DONE when the pixel at index NPIX-1 is accepted.
  - ACTIVE → ACTIVE on i_sof (restart).
  - DONE → ACTIVE on i_sof.
- Pixels are accepted only when state is ACTIVE or i_sof is high. In IDLE and DONE, i_valid without i_sof is ignored.
- On i_sof:
  - mode register ← i_mode.
  - pixel counter ← 0.
  - pack counter and partial word are discarded; nothing is pushed.
  - o_overflow ← 0.
  - A pixel coincident with i_sof is pixel 0 of the new frame and uses the new mode.
- Mode 0:
  - ch0 = {1'b0, G[PIX_W-1 -: 5], B[PIX_W-1 -: 10]}.
  - ch1 = {1'b0, G[PIX_W-6 -: 5], R[PIX_W-1 -: 10]}.
  - One FIFO push per pixel.
- Mode 1: ch0 = ch1 = i_thr ? 16'h7FFF : 16'h0000, zero-extended to WORD_W. One push per pixel.
- Mode 2:
  - The flag of pixel k in the word goes to ch0 bit k; the first pixel is the LSB. ch1 = 0.
  - Push when k = WORD_W-1, or on pixel NPIX-1 with the unfilled high bits zero (frame-end padding).
  - Pack counter wraps to 0 after each push.
- Pixel counter width is $clog2(NPIX). o_frame_done pulses in the cycle after pixel NPIX-1 is accepted, in every mode.
- FIFO rules:
  - At most one push per cycle.
  - A push is accepted if level < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word pair is dropped and o_overflow is set, held until the next i_sof.
  - Pop = o_valid & i_ready. Pop on empty is a no-op.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - state IDLE; mode 0; counters 0.
  - o_valid, o_busy, o_frame_done, o_overflow all 0; o_level 0.
  - o_data0 and o_data1 are 0.
- Latency: a word pushed in cycle N appears on o_data*/o_valid in cycle N+1, show-ahead with no extra read cycle. In modes 0/1 the push cycle is the pixel acceptance cycle.
- o_level updates one cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- o_data* change only after a pop or on the first push into an empty FIFO. The head is held stable while o_valid & !i_ready.
- An asynchronous reset mid-frame clears the FIFO and the FSM immediately. There is no flush.
- Sustained throughput is one pixel per cycle. Drops occur only when the consumer stalls.

## Test plan
- Reset, then mode 0 with PIX_W=12: pulse i_sof, send R=12'hABC, G=12'h5A5, B=12'h3FF with i_ready=1 → next cycle o_valid=1, o_data0=16'h2CFF, o_data1=16'h26AF.
- Mode 1 with FRAME_W=4, FRAME_H=2: send 8 pixels with thr = 1,0,1,1,0,0,0,1 → 8 word pairs of 7FFF/0000 in that order; o_frame_done pulses once, 1 cycle after pixel 7; state ends in DONE.
- Mode 2 with WORD_W=16 and the same 8-pixel frame → exactly one word, o_data0=16'h008D, o_data1=0, padded at frame end. A 9th pixel sent afterwards without i_sof is ignored.
- Mode 2, i_sof reasserted after 5 pixels → partial word discarded, counter restarts, no push. The coincident pixel counts as pixel 0.
- FIFO_DEPTH=4 with i_ready=0 in mode 1: send 6 pixels → o_level=4, o_overflow=1, the first 4 words are intact. Then i_ready=1 → 4 pops in order, o_valid drops after the 4th. o_overflow clears at the next i_sof.
- Full FIFO with push and pop in the same cycle → push accepted, no overflow, o_level stays 4. Asserting i_rst_n=0 mid-stream → all outputs return to their reset values immediately.
